// File: rtl/rob_queue_pkg.sv
// Shared backend definitions for the reorder buffer: default field widths,
// the ROB index width helper and the per-entry status flags.
package rob_queue_pkg;
  localparam int DEPTH_DEF  = 16;
  localparam int PC_W_DEF   = 64;
  localparam int LREG_W_DEF = 5;
  localparam int PREG_W_DEF = 6;

  // ROB index carries one extra wrap bit above the slot index
  function automatic int robidx_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int ROBIDX_W = robidx_w(DEPTH_DEF);

  typedef struct packed {
    logic valid;
    logic complete;
    logic skip;
  } rob_flags_t;
endpackage

// File: rtl/rob_slot.sv
// One reorder-buffer entry: opaque payload plus valid/complete/skip flags.
// Flush beats enqueue, enqueue beats commit-clear, commit-clear beats writeback.
module rob_slot
  import rob_queue_pkg::*;
#(
  parameter int PL_W = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            enq_en,
  input  logic [PL_W-1:0] enq_payload,
  input  logic            wb_set,
  input  logic            wb_skip,
  input  logic            commit_clr,
  input  logic            flush,
  output rob_flags_t      flags,
  output logic [PL_W-1:0] payload
);
  rob_flags_t      flags_q, flags_d;
  logic [PL_W-1:0] payload_q, payload_d;

  always_comb begin
    flags_d   = flags_q;
    payload_d = payload_q;
    if (flush) begin
      flags_d.valid    = 1'b0;
      flags_d.complete = 1'b0;
    end else if (enq_en) begin
      flags_d   = '{valid: 1'b1, complete: 1'b0, skip: 1'b0};
      payload_d = enq_payload;
    end else if (commit_clr) begin
      flags_d.valid    = 1'b0;
      flags_d.complete = 1'b0;
    end else if (wb_set) begin
      flags_d.complete = 1'b1;
      flags_d.skip     = wb_skip;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flags_q   <= '0;
      payload_q <= '0;
    end else begin
      flags_q   <= flags_d;
      payload_q <= payload_d;
    end
  end

  assign flags   = flags_q;
  assign payload = payload_q;
endmodule

// File: rtl/rob_queue.sv
// Reorder buffer: circular queue of rob_slot entries, multi-port writeback,
// in-order commit of up to two entries per cycle, flush to empty.
module rob_queue
  import rob_queue_pkg::*;
#(
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int WB_PORTS = 2,
  parameter  int PC_W     = PC_W_DEF,
  parameter  int LREG_W   = LREG_W_DEF,
  parameter  int PREG_W   = PREG_W_DEF,
  localparam int IW       = robidx_w(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [PC_W-1:0]          enq_pc,
  input  logic [31:0]              enq_instr,
  input  logic [LREG_W-1:0]        enq_lrd,
  input  logic [PREG_W-1:0]        enq_prd,
  input  logic [PREG_W-1:0]        enq_old_prd,
  input  logic                     enq_need_to_wb,
  output logic [IW-1:0]            enq_robidx,
  input  logic [WB_PORTS-1:0]      wb_valid,
  input  logic [WB_PORTS*IW-1:0]   wb_robidx,
  input  logic [WB_PORTS-1:0]      wb_skip,
  output logic [1:0]               commit_valid,
  output logic [1:0][PC_W-1:0]     commit_pc,
  output logic [1:0][LREG_W-1:0]   commit_lrd,
  output logic [1:0][PREG_W-1:0]   commit_prd,
  output logic [1:0][PREG_W-1:0]   commit_old_prd,
  output logic [1:0]               commit_need_to_wb,
  output logic [1:0]               commit_skip,
  input  logic                     flush_vld,
  output logic                     rob_empty
);
  localparam int AW     = IW - 1;
  localparam int LRD_O  = PC_W + 32;
  localparam int PRD_O  = LRD_O + LREG_W;
  localparam int OPRD_O = PRD_O + PREG_W;
  localparam int PL_W   = OPRD_O + PREG_W + 1;

  logic [IW-1:0]              head_q, head_d, tail_q, tail_d;
  rob_flags_t [DEPTH-1:0]     flags;
  logic [DEPTH-1:0][PL_W-1:0] slot_pl;
  logic [PL_W-1:0]            enq_pl;
  logic [1:0][AW-1:0]         hsel;
  logic [1:0][PL_W-1:0]       cpl;
  logic                       full, enq_fire;
  logic                       unused_instr;
  logic [WB_PORTS-1:0]        unused_wb_wrap;

  // full/empty come only from registered pointers
  assign full       = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
  assign enq_ready  = ~full;
  assign rob_empty  = (head_q == tail_q);
  assign enq_robidx = tail_q;
  assign enq_fire   = enq_valid & ~full & ~flush_vld;
  assign enq_pl     = {enq_need_to_wb, enq_old_prd, enq_prd, enq_lrd, enq_instr, enq_pc};

  assign hsel[0] = head_q[AW-1:0];
  assign hsel[1] = head_q[AW-1:0] + AW'(1);
  assign commit_valid[0] = ~flush_vld & flags[hsel[0]].valid & flags[hsel[0]].complete;
  assign commit_valid[1] = commit_valid[0] & flags[hsel[1]].valid & flags[hsel[1]].complete;

  always_comb begin
    head_d = head_q + IW'(commit_valid[0]) + IW'(commit_valid[1]);
    tail_d = tail_q + IW'(enq_fire);
    if (flush_vld) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_slot
    logic hit, hit_skip;

    // concurrent hits on one entry merge by OR
    always_comb begin
      hit      = 1'b0;
      hit_skip = 1'b0;
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && wb_robidx[p*IW +: AW] == AW'(s)) begin
          hit      = 1'b1;
          hit_skip = hit_skip | wb_skip[p];
        end
      end
    end

    rob_slot #(.PL_W(PL_W)) u_slot (
      .clock       (clock),
      .reset_n     (reset_n),
      .enq_en      (enq_fire && tail_q[AW-1:0] == AW'(s)),
      .enq_payload (enq_pl),
      .wb_set      (hit & flags[s].valid),
      .wb_skip     (hit_skip),
      .commit_clr  ((commit_valid[0] && hsel[0] == AW'(s)) ||
                    (commit_valid[1] && hsel[1] == AW'(s))),
      .flush       (flush_vld),
      .flags       (flags[s]),
      .payload     (slot_pl[s])
    );
  end

  for (genvar k = 0; k < 2; k++) begin : g_commit
    assign cpl[k]               = slot_pl[hsel[k]];
    assign commit_pc[k]         = cpl[k][0 +: PC_W];
    assign commit_lrd[k]        = cpl[k][LRD_O +: LREG_W];
    assign commit_prd[k]        = cpl[k][PRD_O +: PREG_W];
    assign commit_old_prd[k]    = cpl[k][OPRD_O +: PREG_W];
    assign commit_need_to_wb[k] = cpl[k][PL_W-1];
    assign commit_skip[k]       = flags[hsel[k]].skip;
  end

  // instruction word is held per entry but no commit port carries it
  assign unused_instr = ^{cpl[0][PC_W +: 32], cpl[1][PC_W +: 32]};
  for (genvar p = 0; p < WB_PORTS; p++) begin : g_wrap
    assign unused_wb_wrap[p] = wb_robidx[p*IW + AW];
  end
endmodule

// File: tb/tb_rob_queue.sv
// Randomized check of rob_queue against a queue-based reorder buffer model.
module tb_rob_queue;
  localparam int DEPTH = 16;
  localparam int IW    = 5;

  logic             clock, reset_n;
  logic             enq_valid, enq_ready, enq_need_to_wb, flush_vld, rob_empty;
  logic [63:0]      enq_pc;
  logic [31:0]      enq_instr;
  logic [4:0]       enq_lrd;
  logic [5:0]       enq_prd, enq_old_prd;
  logic [IW-1:0]    enq_robidx;
  logic [1:0]       wb_valid, wb_skip;
  logic [1:0][IW-1:0] wb_robidx;
  logic [1:0]       commit_valid, commit_need_to_wb, commit_skip;
  logic [1:0][63:0] commit_pc;
  logic [1:0][4:0]  commit_lrd;
  logic [1:0][5:0]  commit_prd, commit_old_prd;

  rob_queue dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc), .enq_instr(enq_instr),
    .enq_lrd(enq_lrd), .enq_prd(enq_prd), .enq_old_prd(enq_old_prd),
    .enq_need_to_wb(enq_need_to_wb), .enq_robidx(enq_robidx),
    .wb_valid(wb_valid), .wb_robidx(wb_robidx), .wb_skip(wb_skip),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_lrd(commit_lrd),
    .commit_prd(commit_prd), .commit_old_prd(commit_old_prd),
    .commit_need_to_wb(commit_need_to_wb), .commit_skip(commit_skip),
    .flush_vld(flush_vld), .rob_empty(rob_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  lrd;
    logic [5:0]  prd, old_prd;
    logic        need;
    bit          complete, skip;
    int          idx;
  } ent_t;

  ent_t q[$];
  int   tailm;
  int   n_chk, n_pass;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] exp_cv();
    logic [1:0] cv;
    cv[0] = (q.size() > 0) && q[0].complete;
    cv[1] = cv[0] && (q.size() > 1) && q[1].complete;
    if (flush_vld) cv = 2'b00;
    return cv;
  endfunction

  task automatic check_outputs();
    logic [1:0] cv;
    cv = exp_cv();
    chk("enq_ready", enq_ready, q.size() != DEPTH);
    chk("enq_robidx", enq_robidx, tailm);
    chk("rob_empty", rob_empty, q.size() == 0);
    chk("commit_valid", commit_valid, cv);
    for (int k = 0; k < 2; k++)
      if (cv[k])
        chk($sformatf("commit%0d_payload", k),
            {commit_pc[k], commit_lrd[k], commit_prd[k], commit_old_prd[k],
             commit_need_to_wb[k], commit_skip[k]},
            {q[k].pc, q[k].lrd, q[k].prd, q[k].old_prd, q[k].need, q[k].skip});
  endtask

  task automatic model_step();
    logic [1:0] cv;
    bit         was_full;
    ent_t       e;
    if (flush_vld) begin
      q.delete();
      tailm = 0;
      return;
    end
    cv       = exp_cv();
    was_full = (q.size() == DEPTH);
    foreach (q[i]) begin
      bit hit, sk;
      hit = 0;
      sk  = 0;
      for (int p = 0; p < 2; p++)
        if (wb_valid[p] && int'(wb_robidx[p][3:0]) == q[i].idx % DEPTH) begin
          hit = 1;
          sk  = sk | wb_skip[p];
        end
      if (hit) begin
        q[i].complete = 1;
        q[i].skip     = sk;
      end
    end
    if (cv[0]) void'(q.pop_front());
    if (cv[1]) void'(q.pop_front());
    if (enq_valid && !was_full) begin
      e = '{pc: enq_pc, lrd: enq_lrd, prd: enq_prd, old_prd: enq_old_prd,
            need: enq_need_to_wb, complete: 0, skip: 0, idx: tailm};
      q.push_back(e);
      tailm = (tailm + 1) % (2 * DEPTH);
    end
  endtask

  task automatic idle();
    enq_valid = 0; wb_valid = 0; wb_skip = 0; wb_robidx = '0; flush_vld = 0;
  endtask

  task automatic enq_rand();
    enq_valid      = 1;
    enq_pc         = {$urandom, $urandom};
    enq_instr      = $urandom;
    enq_lrd        = 5'($urandom);
    enq_prd        = 6'($urandom);
    enq_old_prd    = 6'($urandom);
    enq_need_to_wb = 1'($urandom);
  endtask

  task automatic wb(input int port, input int idx, input bit sk);
    wb_valid[port]  = 1;
    wb_robidx[port] = IW'(idx);
    wb_skip[port]   = sk;
  endtask

  // inputs are driven at the negedge; check, advance model, cross one posedge
  task automatic step();
    #1;
    check_outputs();
    model_step();
    @(posedge clock);
    @(negedge clock);
    idle();
  endtask

  initial begin
    n_chk = 0; n_pass = 0; tailm = 0;
    reset_n = 0;
    idle();
    enq_rand();
    enq_valid = 0;
    #12;
    chk("reset_enq_ready", enq_ready, 1'b1);
    chk("reset_rob_empty", rob_empty, 1'b1);
    chk("reset_commit_valid", commit_valid, 2'b00);
    chk("reset_enq_robidx", enq_robidx, 5'd0);
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);

    // three enqueues, then out-of-order writeback
    repeat (3) begin enq_rand(); step(); end
    wb(0, q[1].idx, 0); step();
    step();
    wb(1, q[0].idx, 1); step();
    step();
    chk("two_commit_head_idx", enq_robidx - 5'(q.size()), 5'd2);

    // fill to full, extra enqueues must be ignored
    repeat (DEPTH + 3) begin enq_rand(); step(); end
    wb(0, q[0].idx, 0); step();
    step();
    step();

    // streaming enqueue with commits to drive pointers through wrap
    repeat (40) begin
      enq_rand();
      if (q.size() > 0) wb(0, q[0].idx, 1'($urandom));
      if (q.size() > 1) wb(1, q[1].idx, 1'($urandom));
      step();
    end

    // random traffic
    repeat (400) begin
      if ($urandom_range(0, 9) < 7) enq_rand();
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 1) == 1) begin
          if (q.size() > 0 && $urandom_range(0, 3) != 0)
            wb(p, q[$urandom_range(0, q.size() - 1)].idx, 1'($urandom));
          else
            wb(p, $urandom_range(0, 2 * DEPTH - 1), 1'($urandom));
        end
      if ($urandom_range(0, 49) == 0) flush_vld = 1;
      step();
    end

    // flush alongside enqueue, writeback and ready commits
    repeat (3) begin enq_rand(); step(); end
    wb(0, q[0].idx, 0); wb(1, q[1].idx, 0); step();
    enq_rand(); wb(0, q[2].idx, 1); flush_vld = 1;
    #1;
    chk("flush_commit_valid", commit_valid, 2'b00);
    #1;
    step();
    chk("flush_rob_empty", rob_empty, 1'b1);
    chk("flush_enq_robidx", enq_robidx, 5'd0);
    step();

    // both ports hit one entry; writeback to an unused slot
    enq_rand(); step();
    wb(0, q[0].idx, 0); wb(1, q[0].idx, 1); step();
    chk("dual_wb_commit_skip", commit_skip[0], 1'b1);
    step();
    enq_rand(); step();
    wb(0, q[0].idx + 3, 1); step();
    chk("wb_empty_no_commit", commit_valid, 2'b00);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rob_queue.md
ROB_QUEUE -- requirements
Module: rob_queue

Interface
REQ-001 SHALL have parameter DEPTH, 16, number of entries (power of two, >=4).
REQ-002 SHALL have parameter WB_PORTS, 2, number of writeback ports.
REQ-003 SHALL have parameter PC_W, 64, PC width.
REQ-004 SHALL have parameter LREG_W, 5, logical register index width.
REQ-005 SHALL have parameter PREG_W, 6, physical register index width.
REQ-006 SHALL have ports, in order:
- clock  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- enq_valid  input  1  enqueue request
- enq_ready  output  1  queue not full
- enq_pc  input  PC_W  PC
- enq_instr  input  32  instruction
- enq_lrd  input  LREG_W  logical destination
- enq_prd  input  PREG_W  new physical destination
- enq_old_prd  input  PREG_W  previous physical mapping
- enq_need_to_wb  input  1  writes a register
- enq_robidx  output  log2(DEPTH)+1  allocated index including wrap bit
- wb_valid  input  WB_PORTS  per-port writeback
- wb_robidx  input  WB_PORTS*(log2(DEPTH)+1)  per-port target index
- wb_skip  input  WB_PORTS  per-port skip flag
- commit_valid  output  2  commit slot valid (slot0 = oldest)
- commit_pc, commit_lrd, commit_prd, commit_old_prd, commit_need_to_wb, commit_skip  output  2x field width  per-slot payload
- flush_vld  input  1  discard all entries
- rob_empty  output  1  no valid entries

Function
REQ-007 SHALL store entries in a circular buffer with head/tail pointers of log2(DEPTH)+1 bits; MSB is the wrap bit.
REQ-008 SHALL define full as equal index bits with differing wrap bits, and empty as equal pointers.
REQ-009 SHALL drive enq_ready = ~full, computed from registered pointers only.
REQ-010 SHALL, on enq_valid & enq_ready, write the payload to the tail entry, set valid=1, complete=0, skip=0, and advance tail by 1 at the clock edge.
REQ-011 SHALL drive enq_robidx = tail combinationally.
REQ-012 SHALL, per port i with wb_valid[i] and a currently valid target entry, set complete=1 and skip=wb_skip[i]; writeback to an invalid entry SHALL be ignored.
REQ-013 SHALL OR complete and skip when two ports hit the same entry in one cycle.
REQ-014 SHALL assert commit_valid[0] when the head entry is valid & complete, and commit_valid[1] only when commit_valid[0] and head+1 is valid & complete (strictly in-order).
REQ-015 SHALL drive commit payloads combinationally from head and head+1 (modulo DEPTH).
REQ-016 SHALL, at the edge, clear valid/complete of committed entries and advance head by popcount(commit_valid).
REQ-017 SHALL permit enqueue and commit in the same cycle; full is evaluated before that cycle's commits.
REQ-018 SHALL not set complete from writeback in the cycle an entry is enqueued.
REQ-019 SHALL give flush_vld priority: force commit_valid=0, clear all valid/complete, set head=tail=0, and ignore enqueue/writeback that cycle.
REQ-020 SHALL drive rob_empty = empty.
REQ-021 SHALL wrap pointers modulo 2*DEPTH with no lost entries.

Reset
REQ-022 SHALL, on reset_n low, asynchronously clear head, tail, and all valid/complete/skip flags, and zero all entry payloads.
REQ-023 SHALL drive, after reset, enq_ready=1, rob_empty=1, commit_valid=0 and enq_robidx=0.

Structure
REQ-024 SHALL take PC_W/LREG_W/PREG_W defaults and the robidx width from the shared backend package.
REQ-025 SHALL instantiate DEPTH copies of sub-module rob_slot, which holds payload, valid, complete and skip, with enq/wb-set/commit-clear/flush inputs.

Verification
REQ-026 Reset, then enqueue 3 instructions -> enq_robidx 0,1,2; rob_empty=0; commit_valid=00.
REQ-027 Writeback idx1 then idx0 (skip=1) -> no commit until idx0 completes; then commit_valid=11, commit_skip slot0=1, head=2.
REQ-028 Enqueue DEPTH entries -> enq_ready=0, and a 17th enq_valid has no effect; one commit -> enq_ready=1 next cycle.
REQ-029 Cycle 40 enqueues with commits -> index 16 wraps to slot 0 with wrap bit 1; payloads match the queued order.
REQ-030 flush_vld concurrent with enq, wb and ready commits -> commit_valid=00; next cycle rob_empty=1, enq_robidx=0.
REQ-031 Both wb ports target the same idx, skip 0/1 -> entry complete, commit_skip=1; wb to an empty slot -> no change.
